// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: memory bus controller between the microprogrammed control
// unit/datapath and MAIN_MEMORY. Takes one read or write request at a time,
// drives the MAIN_MEMORY A/B/RD/WRMain lines and waits for ACK. Read data is
// held in a register, and a one-cycle done pulse lets the sequencer advance.
//
// Ports (DW = DATAWIDTH_BUS):
//   MEM_BUS_CTRL_CLOCK_50       in   1   clock, rising edge
//   MEM_BUS_CTRL_ResetInLow_In  in   1   synchronous active-low reset
//   MEM_BUS_CTRL_Req_In         in   1   access request (sampled in IDLE only)
//   MEM_BUS_CTRL_Write_In       in   1   1 = write, 0 = read
//   MEM_BUS_CTRL_Addr_InBus     in   DW  word address
//   MEM_BUS_CTRL_WrData_InBus   in   DW  write data
//   MEM_BUS_CTRL_Busy_Out       out  1   high in ACCESS and DONE
//   MEM_BUS_CTRL_Done_Out       out  1   one-cycle completion pulse
//   MEM_BUS_CTRL_Error_Out      out  1   one-cycle timeout pulse (with Done)
//   MEM_BUS_CTRL_RdData_OutBus  out  DW  last read data
//   MEM_BUS_CTRL_MemA_OutBus    out  DW  MAIN_MEMORY A (address)
//   MEM_BUS_CTRL_MemB_OutBus    out  DW  MAIN_MEMORY B (write data)
//   MEM_BUS_CTRL_MemRD_Out      out  1   MAIN_MEMORY RD
//   MEM_BUS_CTRL_MemWR_Out      out  1   MAIN_MEMORY WRMain
//   MEM_BUS_CTRL_MemACK_In      in   1   MAIN_MEMORY ACK
//   MEM_BUS_CTRL_MemData_InBus  in   DW  MAIN_MEMORY read data
//
// Build option: define MEM_BUS_CTRL_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES ACCESS cycles without ACK. Without it ACCESS waits forever
// and Error_Out is tied low.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for Req_In; memory strobes low, bus values held
// ACCESS | RD or WR asserted from latched request, waiting for ACK
// DONE   | one-cycle completion (Done_Out, optionally Error_Out)

module mem_bus_ctrl #(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TOUT_W         = 5
) (
  input  logic                     MEM_BUS_CTRL_CLOCK_50,
  input  logic                     MEM_BUS_CTRL_ResetInLow_In,
  input  logic                     MEM_BUS_CTRL_Req_In,
  input  logic                     MEM_BUS_CTRL_Write_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_BUS_CTRL_Addr_InBus,
  input  logic [DATAWIDTH_BUS-1:0] MEM_BUS_CTRL_WrData_InBus,
  output logic                     MEM_BUS_CTRL_Busy_Out,
  output logic                     MEM_BUS_CTRL_Done_Out,
  output logic                     MEM_BUS_CTRL_Error_Out,
  output logic [DATAWIDTH_BUS-1:0] MEM_BUS_CTRL_RdData_OutBus,
  output logic [DATAWIDTH_BUS-1:0] MEM_BUS_CTRL_MemA_OutBus,
  output logic [DATAWIDTH_BUS-1:0] MEM_BUS_CTRL_MemB_OutBus,
  output logic                     MEM_BUS_CTRL_MemRD_Out,
  output logic                     MEM_BUS_CTRL_MemWR_Out,
  input  logic                     MEM_BUS_CTRL_MemACK_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_BUS_CTRL_MemData_InBus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Elaboration-time guard on the timeout parameters.
  if (TIMEOUT_CYCLES < 1 || (2 ** TOUT_W) <= TIMEOUT_CYCLES) begin : g_bad_cfg
    $error("mem_bus_ctrl: TIMEOUT_CYCLES must be >= 1 and < 2**TOUT_W");
  end

  logic [1:0]               state_q;
  logic                     wr_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     mem_rd_q;
  logic                     mem_wr_q;
  logic [DATAWIDTH_BUS-1:0] mem_a_q;
  logic [DATAWIDTH_BUS-1:0] mem_b_q;
  logic [DATAWIDTH_BUS-1:0] rd_data_q;

`ifdef MEM_BUS_CTRL_TIMEOUT_EN
  // Counter value seen on the last ACK-less ACCESS cycle before abort.
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT_CYCLES - 1);
  logic              error_q;
  logic [TOUT_W-1:0] tout_cnt_q;
  assign MEM_BUS_CTRL_Error_Out = error_q;
`else
  assign MEM_BUS_CTRL_Error_Out = 1'b0;
`endif

  always_ff @(posedge MEM_BUS_CTRL_CLOCK_50) begin
    if (!MEM_BUS_CTRL_ResetInLow_In) begin
      state_q   <= ST_IDLE;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_a_q   <= '0;
      mem_b_q   <= '0;
      rd_data_q <= '0;
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
      error_q    <= 1'b0;
      tout_cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
      error_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (MEM_BUS_CTRL_Req_In) begin
            state_q  <= ST_ACCESS;
            wr_q     <= MEM_BUS_CTRL_Write_In;
            mem_a_q  <= MEM_BUS_CTRL_Addr_InBus;
            mem_b_q  <= MEM_BUS_CTRL_WrData_InBus;
            mem_rd_q <= ~MEM_BUS_CTRL_Write_In;
            mem_wr_q <= MEM_BUS_CTRL_Write_In;
            busy_q   <= 1'b1;
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
            tout_cnt_q <= '0;
`endif
          end
        end
        ST_ACCESS: begin
          // ACK takes priority over a timeout expiring on the same edge.
          if (MEM_BUS_CTRL_MemACK_In) begin
            if (!wr_q) rd_data_q <= MEM_BUS_CTRL_MemData_InBus;
            state_q  <= ST_DONE;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            done_q   <= 1'b1;
          end
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
          else if (tout_cnt_q == TOUT_LAST) begin
            state_q  <= ST_DONE;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            done_q   <= 1'b1;
            error_q  <= 1'b1;
          end else begin
            tout_cnt_q <= tout_cnt_q + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign MEM_BUS_CTRL_Busy_Out      = busy_q;
  assign MEM_BUS_CTRL_Done_Out      = done_q;
  assign MEM_BUS_CTRL_RdData_OutBus = rd_data_q;
  assign MEM_BUS_CTRL_MemA_OutBus   = mem_a_q;
  assign MEM_BUS_CTRL_MemB_OutBus   = mem_b_q;
  assign MEM_BUS_CTRL_MemRD_Out     = mem_rd_q;
  assign MEM_BUS_CTRL_MemWR_Out     = mem_wr_q;

endmodule
